// File: rtl/switch_pio_scanner.sv
// switch_pio_scanner
//
// Avalon-MM master for the single-bit switch PIO. After reset it writes the
// PIO irq mask. It then reads the data register on a fixed interval, or early
// after a rising edge on pio_irq. The sampled bit is debounced into a clean
// switch level with a one-cycle change pulse.
//
// All outputs are registered. The bus values for a state are loaded on the
// edge that enters that state. The one exception is the irq-mask write. INIT
// holds the reset bus values, and the write is loaded on the edge leaving
// INIT, so it is visible during the first IDLE cycle.
//
// Ports
//   clk             system clock, rising edge
//   reset_n         synchronous active-low reset
//   enable          polling enable (the init write happens regardless)
//   pio_address     PIO register address (0 = data, 2 = irq mask)
//   pio_chipselect  PIO select
//   pio_write_n     PIO write strobe, active-low
//   pio_writedata   PIO write data
//   pio_readdata    PIO read data, valid the cycle after the address; bit 0 used
//   pio_irq         PIO level interrupt
//   switch_state    debounced switch level
//   switch_event    one-cycle pulse when switch_state changes
//   busy            high while the FSM is not in IDLE
module switch_pio_scanner #(
    parameter int unsigned POLL_CYCLES  = 50000,
    parameter int unsigned STABLE_COUNT = 4,
    parameter int unsigned IRQ_ENABLE   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    input  logic        pio_irq,
    output logic        switch_state,
    output logic        switch_event,
    output logic        busy
);

    localparam int unsigned TW = $clog2(POLL_CYCLES);
    localparam int unsigned CW = $clog2(STABLE_COUNT + 1);
    localparam logic [TW-1:0] TimerReload = TW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] CountMax    = CW'(STABLE_COUNT);

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StRdAddr,
        StRdWait
    } state_e;

    state_e        state;
    logic [TW-1:0] timer;
    logic          poll_pending;
    logic          irq_q;
    logic          candidate;
    logic [CW-1:0] count;

    logic          irq_rise;
    logic          sample;
    logic          candidate_d;
    logic [CW-1:0] count_d;
    logic          accept;

    // Only bit 0 of the PIO data register carries the switch.
    logic unused_readdata;
    assign unused_readdata = ^pio_readdata[31:1];

    // Debounce next-state. It is only committed in RD_WAIT.
    always_comb begin
        irq_rise    = pio_irq & ~irq_q;
        sample      = pio_readdata[0];
        candidate_d = candidate;
        count_d     = count;
        if (sample != candidate) begin
            candidate_d = sample;
            count_d     = CW'(1);
        end else if (count != CountMax) begin
            count_d = count + CW'(1);
        end
        accept = (count_d == CountMax) && (candidate_d != switch_state);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= StInit;
            timer          <= TimerReload;
            poll_pending   <= 1'b0;
            irq_q          <= 1'b0;
            candidate      <= 1'b0;
            count          <= '0;
            pio_address    <= 2'd0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= 32'd0;
            switch_state   <= 1'b0;
            switch_event   <= 1'b0;
            busy           <= 1'b1;
        end else begin
            irq_q        <= pio_irq;
            switch_event <= 1'b0;

            case (state)
                StInit: begin
                    // irq-mask write is presented in the cycle after INIT.
                    state          <= StIdle;
                    timer          <= TimerReload;
                    poll_pending   <= 1'b0;
                    pio_address    <= 2'd2;
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_writedata  <= 32'(IRQ_ENABLE);
                    busy           <= 1'b0;
                end

                StIdle: begin
                    pio_address    <= 2'd0;
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    pio_writedata  <= 32'd0;
                    busy           <= 1'b0;
                    if (!enable) begin
                        timer        <= TimerReload;
                        poll_pending <= 1'b0;
                    end else if (timer == '0 || poll_pending) begin
                        state          <= StRdAddr;
                        timer          <= TimerReload;
                        // A rise on the entry cycle still queues one more read.
                        poll_pending   <= irq_rise;
                        pio_chipselect <= 1'b1;
                        busy           <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                        if (irq_rise) begin
                            poll_pending <= 1'b1;
                        end
                    end
                end

                StRdAddr: begin
                    // Slave registers the read, so the select is a single cycle.
                    state          <= StRdWait;
                    pio_chipselect <= 1'b0;
                    busy           <= 1'b1;
                    if (enable && irq_rise) begin
                        poll_pending <= 1'b1;
                    end
                end

                StRdWait: begin
                    state     <= StIdle;
                    busy      <= 1'b0;
                    candidate <= candidate_d;
                    count     <= count_d;
                    if (accept) begin
                        switch_state <= candidate_d;
                        switch_event <= 1'b1;
                    end
                    if (enable && irq_rise) begin
                        poll_pending <= 1'b1;
                    end
                end

                default: begin
                    state <= StInit;
                end
            endcase
        end
    end

endmodule
